// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared reset values and duty-slice indexing for the multi-channel PWM
package pwm_pkg;

    localparam logic PERIOD_RST_BIT = 1'b1;
    localparam logic DUTY_RST_BIT   = 1'b0;

    function automatic int duty_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_multi_ramp_if.sv
// rtl/pwm_multi_ramp_if.sv - control/status bundle between a PWM user and pwm_multi_ramp
interface pwm_multi_ramp_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8
) ();
    logic                      enable;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty_in;
    logic                      duty_load;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_tick;
    logic [CHANNELS-1:0]       at_target;

    modport master (
        output enable, period, duty_in, duty_load,
        input  pwm_out, period_tick, at_target
    );

    modport slave (
        input  enable, period, duty_in, duty_load,
        output pwm_out, period_tick, at_target
    );
endinterface

// File: rtl/pwm_ramp_channel.sv
// rtl/pwm_ramp_channel.sv - one PWM channel: double-buffered duty, slew-limited applied duty, output compare
module pwm_ramp_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RAMP_STEP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] counter_i,
    input  logic             wrap_i,
    input  logic             duty_load_i,
    input  logic [WIDTH-1:0] duty_i,
    output logic             pwm_o,
    output logic             at_target_o
);

    // A step at least as large as the full range always lands on target, so clamp it to fit WIDTH bits.
    localparam logic [WIDTH-1:0] STEP =
        (RAMP_STEP >= (1 << WIDTH)) ? {WIDTH{1'b1}} : WIDTH'(RAMP_STEP);

    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             pwm_q, pwm_d;
    logic             up;
    logic [WIDTH:0]   diff_x;

    always_comb begin
        up       = target_q > active_q;
        diff_x   = up ? ({1'b0, target_q} - {1'b0, active_q})
                      : ({1'b0, active_q} - {1'b0, target_q});
        target_d = duty_load_i ? duty_i : target_q;
        active_d = active_q;
        if (wrap_i) begin
            if ((RAMP_STEP == 0) || (diff_x <= {1'b0, STEP})) begin
                active_d = target_q;
            end else begin
                active_d = up ? (active_q + STEP) : (active_q - STEP);
            end
        end
        pwm_d = enable_i && (counter_i < active_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q <= {WIDTH{DUTY_RST_BIT}};
            active_q <= {WIDTH{DUTY_RST_BIT}};
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o       = pwm_q;
    assign at_target_o = (active_q == target_q);

endmodule

// File: rtl/pwm_multi_ramp.sv
// rtl/pwm_multi_ramp.sv - multi-channel PWM: prescaler, shared period counter, period shadow, channel array
module pwm_multi_ramp
    import pwm_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 1,
    parameter int RAMP_STEP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_multi_ramp_if.slave   bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [WIDTH-1:0]    counter_q, counter_d;
    logic [WIDTH-1:0]    period_act_q, period_act_d;
    logic                tick_q, tick_d;
    logic                step;
    logic                wrap;
    logic [CHANNELS-1:0] pwm_vec;
    logic [CHANNELS-1:0] at_vec;

    always_comb begin
        step         = (presc_q == PRESC_LAST);
        wrap         = bus.enable && step && (counter_q == period_act_q);
        presc_d      = presc_q;
        counter_d    = counter_q;
        period_act_d = period_act_q;
        tick_d       = 1'b0;
        if (!bus.enable) begin
            presc_d   = '0;
            counter_d = '0;
        end else begin
            presc_d = step ? '0 : (presc_q + 1'b1);
            if (step) begin
                counter_d = wrap ? '0 : (counter_q + 1'b1);
            end
        end
        // The new period is only picked up at wrap so a running period is never cut short.
        if (wrap) begin
            tick_d       = 1'b1;
            period_act_d = bus.period;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            counter_q    <= '0;
            period_act_q <= {WIDTH{PERIOD_RST_BIT}};
            tick_q       <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            counter_q    <= counter_d;
            period_act_q <= period_act_d;
            tick_q       <= tick_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_ramp_channel #(
            .WIDTH     (WIDTH),
            .RAMP_STEP (RAMP_STEP)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable_i    (bus.enable),
            .counter_i   (counter_q),
            .wrap_i      (wrap),
            .duty_load_i (bus.duty_load),
            .duty_i      (bus.duty_in[duty_lsb(g, WIDTH) +: WIDTH]),
            .pwm_o       (pwm_vec[g]),
            .at_target_o (at_vec[g])
        );
    end

    assign bus.pwm_out     = pwm_vec;
    assign bus.at_target   = at_vec;
    assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_pwm_multi_ramp.sv
// tb/tb_pwm_multi_ramp.sv - self-checking bench: two configurations against a behavioural model
module tb_pwm_multi_ramp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        duty_load;
    logic [7:0]  period;
    logic [15:0] duty_in;

    always #5 clk = ~clk;

    pwm_multi_ramp_if #(.CHANNELS(2), .WIDTH(8)) if0 ();
    pwm_multi_ramp_if #(.CHANNELS(2), .WIDTH(8)) if1 ();

    assign if0.enable    = enable;
    assign if0.period    = period;
    assign if0.duty_in   = duty_in;
    assign if0.duty_load = duty_load;
    assign if1.enable    = enable;
    assign if1.period    = period;
    assign if1.duty_in   = duty_in;
    assign if1.duty_load = duty_load;

    pwm_multi_ramp #(.CHANNELS(2), .WIDTH(8), .PRESCALE(1), .RAMP_STEP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    pwm_multi_ramp #(.CHANNELS(2), .WIDTH(8), .PRESCALE(4), .RAMP_STEP(16)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Behavioural model: per instance, prescale phase, step count, period in force, target/applied duty.
    int PSC [2] = '{1, 4};
    int RMP [2] = '{0, 16};
    int ps [2];
    int cnt [2];
    int pact [2];
    int tgt [2][2];
    int act [2][2];
    int epwm [2][2];
    int etick [2];
    bit mvalid = 1'b0;

    function automatic int approach(input int a, input int t, input int r);
        if (r == 0) return t;
        if (t > a) return (t - a <= r) ? t : a + r;
        return (a - t <= r) ? t : a - r;
    endfunction

    always @(posedge clk) begin
        int nps, ncnt, npact, ntick;
        int nact [2];
        int ntgt [2];
        int np [2];
        for (int m = 0; m < 2; m++) begin
            nps = 0; ncnt = 0; npact = pact[m]; ntick = 0;
            for (int c = 0; c < 2; c++) begin
                np[c]   = 0;
                nact[c] = act[m][c];
                ntgt[c] = duty_load ? int'(duty_in[c*8 +: 8]) : tgt[m][c];
            end
            if (!rst_n) begin
                npact = 255;
                for (int c = 0; c < 2; c++) begin
                    nact[c] = 0;
                    ntgt[c] = 0;
                end
            end else if (enable) begin
                for (int c = 0; c < 2; c++) np[c] = (cnt[m] < act[m][c]) ? 1 : 0;
                nps  = ps[m] + 1;
                ncnt = cnt[m];
                if (ps[m] == PSC[m] - 1) begin
                    nps = 0;
                    if (cnt[m] == pact[m]) begin
                        ncnt  = 0;
                        ntick = 1;
                        npact = int'(period);
                        for (int c = 0; c < 2; c++)
                            nact[c] = approach(act[m][c], tgt[m][c], RMP[m]);
                    end else begin
                        ncnt = cnt[m] + 1;
                    end
                end
            end
            ps[m]    <= nps;
            cnt[m]   <= ncnt;
            pact[m]  <= npact;
            etick[m] <= ntick;
            for (int c = 0; c < 2; c++) begin
                act[m][c]  <= nact[c];
                tgt[m][c]  <= ntgt[c];
                epwm[m][c] <= np[c];
            end
        end
        if (!rst_n) mvalid <= 1'b1;
    end

    function automatic logic [1:0] pw(input int m);
        return (m == 0) ? if0.pwm_out : if1.pwm_out;
    endfunction
    function automatic logic tk(input int m);
        return (m == 0) ? if0.period_tick : if1.period_tick;
    endfunction
    function automatic logic [1:0] at(input int m);
        return (m == 0) ? if0.at_target : if1.at_target;
    endfunction

    always @(negedge clk) begin
        logic [1:0] p, a;
        if (mvalid) begin
            for (int m = 0; m < 2; m++) begin
                p = pw(m);
                a = at(m);
                check($sformatf("u%0d tick", m), int'(tk(m)), etick[m]);
                for (int c = 0; c < 2; c++) begin
                    check($sformatf("u%0d pwm%0d", m, c), int'(p[c]), epwm[m][c]);
                    check($sformatf("u%0d at_target%0d", m, c), int'(a[c]),
                          (act[m][c] == tgt[m][c]) ? 1 : 0);
                end
            end
        end
    end

    task automatic sync_tick(input int m);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (tk(m)) return;
        end
        check("sync_tick timeout", 0, 1);
    endtask

    // Starting at a tick cycle, counts cycles and high outputs up to and including the next tick.
    task automatic measure(input int m, input int ld_off, input logic [15:0] ld_val,
                           output int cyc, output int h0, output int h1);
        logic [1:0] p;
        cyc = 0; h0 = 0; h1 = 0;
        if (ld_off == 0) begin
            duty_in   = ld_val;
            duty_load = 1'b1;
        end
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            duty_load = (n == ld_off);
            if (n == ld_off) duty_in = ld_val;
            p  = pw(m);
            h0 += int'(p[0]);
            h1 += int'(p[1]);
            if (tk(m)) begin
                cyc = n;
                return;
            end
        end
        check("measure timeout", 0, 1);
    endtask

    task automatic load(input logic [15:0] v);
        @(negedge clk);
        duty_in   = v;
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
    endtask

    task automatic set_and_measure(input int m, input logic [7:0] p, input logic [15:0] v,
                                   output int cyc, output int h0, output int h1);
        @(negedge clk);
        period = p;
        load(v);
        sync_tick(m);
        measure(m, -1, 16'h0, cyc, h0, h1);
        measure(m, -1, 16'h0, cyc, h0, h1);
    endtask

    initial begin
        int cyc, h0, h1;
        int exp_ramp [8] = '{64, 128, 192, 200, 136, 72, 8, 0};
        rst_n = 1'b0; enable = 1'b0; duty_load = 1'b0; period = 8'd0; duty_in = 16'h0;
        repeat (3) @(negedge clk);
        check("reset u0 pwm", int'(if0.pwm_out), 0);
        check("reset u0 tick", int'(if0.period_tick), 0);
        check("reset u0 at_target", int'(if0.at_target), 3);
        check("reset u1 at_target", int'(if1.at_target), 3);
        rst_n = 1'b1;

        period = 8'd9;
        enable = 1'b1;
        load(16'h0003);
        sync_tick(0);
        measure(0, -1, 16'h0, cyc, h0, h1);
        check("p9 d3 period", cyc, 10);
        check("p9 d3 ch0 high", h0, 3);
        check("p9 d3 ch1 high", h1, 0);

        measure(0, 4, 16'h0007, cyc, h0, h1);
        check("load mid-period old duty", h0, 3);
        measure(0, -1, 16'h0, cyc, h0, h1);
        check("load mid-period new duty", h0, 7);
        measure(0, 9, 16'h0002, cyc, h0, h1);
        check("load on wrap cur", h0, 7);
        measure(0, -1, 16'h0, cyc, h0, h1);
        check("load on wrap +1", h0, 7);
        measure(0, -1, 16'h0, cyc, h0, h1);
        check("load on wrap +2", h0, 2);

        set_and_measure(0, 8'd9, {8'd10, 8'd0}, cyc, h0, h1);
        check("duty 0 never high", h0, 0);
        check("duty 10 always high", h1, 10);
        set_and_measure(0, 8'd9, {8'd255, 8'd255}, cyc, h0, h1);
        check("duty 255 always high", h0, 10);
        set_and_measure(0, 8'd0, {8'd0, 8'd1}, cyc, h0, h1);
        check("period 0 length", cyc, 1);
        check("period 0 duty 1", h0, 1);
        check("period 0 duty 0", h1, 0);

        set_and_measure(0, 8'd9, 16'h0003, cyc, h0, h1);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("disable pwm", int'(if0.pwm_out), 0);
        repeat (4) @(negedge clk);
        enable = 1'b1;
        measure(0, -1, 16'h0, cyc, h0, h1);
        check("re-enable period", cyc, 10);
        check("re-enable duty", h0, 3);

        rst_n = 1'b0;
        @(negedge clk);
        check("mid-run reset u1 at_target", int'(if1.at_target), 3);
        check("mid-run reset u1 pwm", int'(if1.pwm_out), 0);
        rst_n  = 1'b1;
        period = 8'd255;
        load(16'h0032);
        check("ramp at_target after load", int'(if1.at_target), 2);
        sync_tick(1);
        for (int k = 0; k < 8; k++) begin
            measure(1, (k == 3) ? 10 : -1, 16'h0000, cyc, h0, h1);
            check($sformatf("ramp window %0d", k), h0, exp_ramp[k]);
            if (k == 0) check("ramp period clk", cyc, 1024);
            if (k == 1) check("ramp at_target mid", int'(if1.at_target[0]), 0);
            if (k == 2) check("ramp at_target done", int'(if1.at_target[0]), 1);
        end

        period = 8'd3;
        sync_tick(1);
        measure(1, -1, 16'h0, cyc, h0, h1);
        measure(1, -1, 16'h0, cyc, h0, h1);
        check("prescale p3 period", cyc, 16);
        period = 8'd7;
        measure(1, -1, 16'h0, cyc, h0, h1);
        check("period change old completes", cyc, 16);
        measure(1, -1, 16'h0, cyc, h0, h1);
        check("period change new", cyc, 32);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            duty_load = ($urandom % 8) == 0;
            duty_in   = 16'($urandom);
            if (($urandom % 64) == 0) period = 8'($urandom_range(0, 12));
            if (($urandom % 97) == 0) enable = ~enable;
            rst_n = (($urandom % 500) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; duty_load = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
